pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 6, number of tracked pipeline stages (legal 3..8); stage 0 is the issue stage, stage NUM_STAGES-1 is the oldest.
REQ-002 Parameter BR_STAGE, default 3, index of the stage that resolves branches (legal 1..NUM_STAGES-2).
REQ-003 Parameter RA_W, default 4, register address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 instr_valid_in  in  1  an instruction is offered for issue.
REQ-007 src_addr_in  in  3*RA_W  source registers {rs,rm,rn}.
REQ-008 src_use_in  in  3  per-source use flags.
REQ-009 rd_in / rd_wr_in  in  RA_W / 1  destination register and its write flag.
REQ-010 branch_taken_in  in  1  taken branch resolved in stage BR_STAGE.
REQ-011 halt_in / resume_in  in  1 / 1  drain request and restart request.
REQ-012 instr_ready  out  1  the offered instruction is accepted this cycle.
REQ-013 stage_valid  out  NUM_STAGES  per-stage occupancy.
REQ-014 stall / flush_mask  out  1 / NUM_STAGES  hazard stall indicator and stages cleared this cycle.
REQ-015 load_pc / sel_pc  out  1 / 2  PC load strobe; source select 00 = PC+4, 01 = reset vector, 10 = branch target.
REQ-016 halted  out  1  the pipeline is empty and stopped.

Function
REQ-017 FSM states: BOOT, RUN, DRAIN, HALTED; BOOT->RUN after exactly one cycle; RUN->DRAIN on halt_in; DRAIN->HALTED in the cycle where stage_valid becomes all-zero; HALTED->RUN on resume_in.
REQ-018 In BOOT, the block drives load_pc=1, sel_pc=01 and instr_ready=0.
REQ-019 All stages advance every cycle: valid and tag of stage i move to i+1, and stage NUM_STAGES-1 retires; there is no downstream backpressure.
REQ-020 In RUN, instr_ready = !stall; an accepted instruction enters stage 0 with tag {rd_in, rd_wr_in}, and load_pc=1, sel_pc=00 in the same cycle.
REQ-021 Hazard: stall=1 when instr_valid_in, state RUN, and any used source equals rd of a valid, writing stage in 0..NUM_STAGES-2; stage NUM_STAGES-1 is not checked because the register file writes through.
REQ-022 On stall, a bubble (valid=0) enters stage 0, older stages still advance, and load_pc=0.
REQ-023 Branch: branch_taken_in with stage_valid[BR_STAGE]=1 drives flush_mask bits 0..BR_STAGE-1 high, clears those stages next cycle, and drives load_pc=1, sel_pc=10.
REQ-024 On a branch flush, an instruction offered in the same cycle is accepted (instr_ready=1) and discarded.
REQ-025 branch_taken_in is ignored when stage_valid[BR_STAGE]=0.
REQ-026 Branch flush and hazard in the same cycle: flush wins and stall=0.
REQ-027 In DRAIN and HALTED, instr_ready=0 and stall=0; branches still flush.
REQ-028 halt_in in the same cycle as an accepted instruction: the instruction is issued, then the FSM enters DRAIN.
REQ-029 halted=1 only in HALTED.
REQ-030 When no other rule applies, load_pc=0, sel_pc=00 and flush_mask=0.

Reset
REQ-031 While rst=1: state=BOOT, stage_valid=0, tags=0, counters=0, instr_ready=0, stall=0, flush_mask=0, halted=0, load_pc=0, sel_pc=00.
REQ-032 rst asserted mid-operation discards all in-flight stages within one cycle, and the first cycle after release is BOOT.

Configuration
REQ-033 Macro PIPE_PERF_CNT_EN, when defined, adds 32-bit outputs stall_cnt and flush_cnt.
REQ-034 With PIPE_PERF_CNT_EN defined, stall_cnt increments on each stall=1 cycle and flush_cnt on each effective branch flush, both saturating at 0xFFFFFFFF.
REQ-035 Without PIPE_PERF_CNT_EN, the stall_cnt and flush_cnt ports and their logic are absent, and all other behaviour is identical.

Verification
REQ-036 Release rst -> one cycle of load_pc=1, sel_pc=01, instr_ready=0, then RUN with instr_ready=1.
REQ-037 Issue rd=3 writing, next instr with rn=3 used -> stall=1 for NUM_STAGES-1 cycles (5 at default), then accepted.
REQ-038 Fill stages 0..5 valid, branch_taken_in=1 -> flush_mask=6'b000111, stages 0..2 clear next cycle, load_pc=1, sel_pc=10.
REQ-039 Hazard and taken branch in the same cycle -> stall=0, instr_ready=1, the instruction is discarded.
REQ-040 halt_in with 4 stages valid -> DRAIN, halted=1 after the pipe empties; resume_in -> RUN next cycle.
REQ-041 PIPE_PERF_CNT_EN defined, 7 stall cycles and 2 flushes -> stall_cnt=7, flush_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: issue control, RAW hazard stall, branch flush and halt/drain sequencing for an in-order pipe.
// Optional PIPE_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int BR_STAGE = 3,
  parameter int RA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid_in,
  input  logic [3*RA_W-1:0]     src_addr_in,
  input  logic [2:0]            src_use_in,
  input  logic [RA_W-1:0]       rd_in,
  input  logic                  rd_wr_in,
  input  logic                  branch_taken_in,
  input  logic                  halt_in,
  input  logic                  resume_in,
  output logic                  instr_ready,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  stall,
  output logic [NUM_STAGES-1:0] flush_mask,
  output logic                  load_pc,
  output logic [1:0]            sel_pc,
  output logic                  halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;
  localparam logic [NUM_STAGES-1:0] YOUNG = NUM_STAGES'((1 << BR_STAGE) - 1);
  state_t state;
  logic [RA_W:0] tag [NUM_STAGES];
  logic hazard, run, flush, accept;
  logic [NUM_STAGES-1:0] alive, nv;
  // stage NUM_STAGES-1 is skipped: the register file writes through
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_STAGES - 1; i++)
      for (int j = 0; j < 3; j++)
        if (src_use_in[j] && stage_valid[i] && tag[i][0] && tag[i][RA_W:1] == src_addr_in[j*RA_W +: RA_W])
          hazard = 1'b1;
  end
  assign run = !rst && state == RUN;
  assign flush = !rst && branch_taken_in && stage_valid[BR_STAGE];
  assign stall = run && instr_valid_in && hazard && !flush;
  assign instr_ready = run && !stall;
  assign accept = instr_ready && instr_valid_in && !flush;
  assign flush_mask = flush ? YOUNG : '0;
  assign load_pc = !rst && (state == BOOT || flush || accept);
  assign sel_pc = rst ? 2'b00 : state == BOOT ? 2'b01 : flush ? 2'b10 : 2'b00;
  assign halted = !rst && state == HALTED;
  assign alive = stage_valid & ~flush_mask;
  assign nv = {alive[NUM_STAGES-2:0], accept};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      stage_valid <= '0;
      for (int i = 0; i < NUM_STAGES; i++) tag[i] <= '0;
    end else begin
      stage_valid <= nv;
      tag[0] <= accept ? {rd_in, rd_wr_in} : '0;
      for (int i = 1; i < NUM_STAGES; i++) tag[i] <= tag[i-1];
      state <= state == BOOT ? RUN :
               state == RUN && halt_in ? DRAIN :
               state == DRAIN && nv == '0 ? HALTED :
               state == HALTED && resume_in ? RUN : state;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of boot, hazard stall, branch flush, drain/halt and mid-run reset.
module tb_pipeline_sequencer;
  localparam int NS = 6;
  localparam int RW = 4;
  logic clk = 1'b0;
  logic rst, instr_valid_in, rd_wr_in, branch_taken_in, halt_in, resume_in;
  logic [3*RW-1:0] src_addr_in;
  logic [2:0] src_use_in;
  logic [RW-1:0] rd_in;
  logic instr_ready, stall, load_pc, halted;
  logic [NS-1:0] stage_valid, flush_mask;
  logic [1:0] sel_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int errors = 0;
  int checks = 0;
  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid_in(instr_valid_in), .src_addr_in(src_addr_in),
    .src_use_in(src_use_in), .rd_in(rd_in), .rd_wr_in(rd_wr_in),
    .branch_taken_in(branch_taken_in), .halt_in(halt_in), .resume_in(resume_in),
    .instr_ready(instr_ready), .stage_valid(stage_valid), .stall(stall),
    .flush_mask(flush_mask), .load_pc(load_pc), .sel_pc(sel_pc), .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; instr_valid_in = 1'b0; src_addr_in = '0; src_use_in = 3'b000;
    rd_in = '0; rd_wr_in = 1'b0; branch_taken_in = 1'b0; halt_in = 1'b0; resume_in = 1'b0;
    tick(); tick();
    #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_load_pc", load_pc, 0);
    chk("rst_sel_pc", sel_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_valid", stage_valid, 0);
    chk("rst_fmask", flush_mask, 0);
    rst = 1'b0;
    #1;
    chk("boot_load_pc", load_pc, 1);
    chk("boot_sel_pc", sel_pc, 2'b01);
    chk("boot_ready", instr_ready, 0);
    tick();
    chk("run_ready", instr_ready, 1);
    chk("run_idle_load_pc", load_pc, 0);
    instr_valid_in = 1'b1; rd_in = 4'd3; rd_wr_in = 1'b1;
    #1;
    chk("issue_ready", instr_ready, 1);
    chk("issue_load_pc", load_pc, 1);
    chk("issue_sel_pc", sel_pc, 0);
    tick();
    chk("issue_valid", stage_valid, 6'b000001);
    rd_in = 4'd0; rd_wr_in = 1'b0; src_addr_in = {4'd0, 4'd0, 4'd3}; src_use_in = 3'b001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("haz_stall", stall, 1);
      chk("haz_ready", instr_ready, 0);
      chk("haz_load_pc", load_pc, 0);
      tick();
    end
    chk("haz_bubbles", stage_valid, 6'b100000);
    chk("haz_release_stall", stall, 0);
    chk("haz_release_ready", instr_ready, 1);
    tick();
    chk("haz_accepted", stage_valid, 6'b000001);
    src_use_in = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    chk("fill_all", stage_valid, 6'b111111);
    branch_taken_in = 1'b1;
    #1;
    chk("br_fmask", flush_mask, 6'b000111);
    chk("br_load_pc", load_pc, 1);
    chk("br_sel_pc", sel_pc, 2'b10);
    chk("br_ready", instr_ready, 1);
    tick();
    branch_taken_in = 1'b0; instr_valid_in = 1'b0;
    chk("br_cleared", stage_valid, 6'b110000);
    instr_valid_in = 1'b1; rd_in = 4'd5; rd_wr_in = 1'b1;
    tick();
    rd_wr_in = 1'b0; rd_in = 4'd0;
    tick(); tick(); tick();
    chk("bh_setup", stage_valid, 6'b001111);
    src_addr_in = {4'd0, 4'd0, 4'd5}; src_use_in = 3'b001;
    #1;
    chk("bh_stall_alone", stall, 1);
    branch_taken_in = 1'b1;
    #1;
    chk("bh_stall", stall, 0);
    chk("bh_ready", instr_ready, 1);
    chk("bh_fmask", flush_mask, 6'b000111);
    tick();
    branch_taken_in = 1'b0; instr_valid_in = 1'b0; src_use_in = 3'b000;
    chk("bh_discard", stage_valid, 6'b010000);
    branch_taken_in = 1'b1;
    #1;
    chk("br_ignored_fmask", flush_mask, 0);
    chk("br_ignored_load_pc", load_pc, 0);
    branch_taken_in = 1'b0;
    instr_valid_in = 1'b1;
    tick(); tick(); tick(); tick();
    chk("halt_setup", stage_valid, 6'b001111);
    halt_in = 1'b1;
    #1;
    chk("halt_issue_ready", instr_ready, 1);
    tick();
    halt_in = 1'b0;
    #1;
    chk("drain_valid", stage_valid, 6'b011111);
    chk("drain_ready", instr_ready, 0);
    chk("drain_stall", stall, 0);
    instr_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain_not_halted", halted, 0);
    end
    tick();
    chk("halted", halted, 1);
    chk("halted_empty", stage_valid, 0);
    resume_in = 1'b1;
    #1;
    chk("halted_ready", instr_ready, 0);
    tick();
    resume_in = 1'b0;
    chk("resumed_halted", halted, 0);
    chk("resumed_ready", instr_ready, 1);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 5);
    chk("flush_cnt", flush_cnt, 2);
`endif
    instr_valid_in = 1'b1;
    tick();
    instr_valid_in = 1'b0;
    chk("pre_rst_valid", stage_valid, 6'b000001);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", stage_valid, 0);
    chk("mid_rst_load_pc", load_pc, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    rst = 1'b0;
    #1;
    chk("reboot_load_pc", load_pc, 1);
    chk("reboot_sel_pc", sel_pc, 2'b01);
    tick();
    chk("reboot_ready", instr_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
